// File: rtl/alarm_bank_if.sv
// Purpose : signal bundle between a watcher client and the alarm_bank watchdog.
// Latency : pure wiring, no state.
// Backpressure: none; engage/clr are levels, alarm outputs are status.
// Ports   : engage/clr driven by master; talarm, talarm_ch, alarm_id, fired
//           driven by slave (the alarm_bank).
interface alarm_bank_if #(
   parameter int CHANNELS = 4
);
   localparam int ID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0] engage;
   logic [CHANNELS-1:0] clr;
   logic                talarm;
   logic [CHANNELS-1:0] talarm_ch;
   logic [ID_W-1:0]     alarm_id;
   logic [CHANNELS-1:0] fired;

   modport master (
      output engage, clr,
      input  talarm, talarm_ch, alarm_id, fired
   );

   modport slave (
      input  engage, clr,
      output talarm, talarm_ch, alarm_id, fired
   );
endinterface

// File: rtl/alarm_bank.sv
// Purpose : bank of per-channel watchdogs; an engagement left unanswered for
//           ALARM_DLY_TICKS+1 edges raises a single ALARM_TICKS+1 cycle alarm.
// Latency : alarm outputs are combinational decodes of registered state.
// Backpressure: none; engage is a level, one engagement yields at most one alarm.
// Ports   : clk_sys, rst (async, active-high); bus.engage/bus.clr in;
//           bus.talarm, bus.talarm_ch, bus.alarm_id, bus.fired out.
module alarm_bank #(
   parameter int CHANNELS        = 4,
   parameter int ALARM_DLY_TICKS = 32,
   parameter int ALARM_TICKS     = 4
) (
   input  logic        clk_sys,
   input  logic        rst,
   alarm_bank_if.slave bus
);
   localparam int MAX_TICKS = (ALARM_DLY_TICKS > ALARM_TICKS) ? ALARM_DLY_TICKS : ALARM_TICKS;
   // A zero-width counter is not legal; both loads of 0 still fit in one bit.
   localparam int CNT_W = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;
   localparam int ID_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(ALARM_DLY_TICKS);
   localparam logic [CNT_W-1:0] ALM_LOAD = CNT_W'(ALARM_TICKS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ALARM, S_HOLD} state_t;

   state_t              state_q [CHANNELS];
   state_t              state_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q   [CHANNELS];
   logic [CNT_W-1:0]    cnt_d   [CHANNELS];
   logic [CHANNELS-1:0] fired_q;
   logic [CHANNELS-1:0] fired_d;
   logic [CHANNELS-1:0] alarm_vec;
   logic [ID_W-1:0]     alarm_idx;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         fired_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         fired_q <= fired_d;
      end
   end

   always_comb begin
      fired_d = fired_q;
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (bus.engage[i]) begin
                  state_d[i] = S_WAIT;
                  cnt_d[i]   = DLY_LOAD;
               end
            end
            S_WAIT: begin
               // An answer arriving on the expiry cycle still cancels the alarm.
               if (!bus.engage[i]) begin
                  state_d[i] = S_IDLE;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = S_ALARM;
                  cnt_d[i]   = ALM_LOAD;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            S_ALARM: begin
               // Alarm runs its full length regardless of engage.
               if (cnt_q[i] == '0) begin
                  state_d[i] = S_HOLD;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            S_HOLD: begin
               // Wait for the engagement to end so it cannot re-alarm.
               if (!bus.engage[i]) begin
                  state_d[i] = S_IDLE;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
            end
         endcase

         // Entry into S_ALARM beats a simultaneous clear.
         if ((state_q[i] != S_ALARM) && (state_d[i] == S_ALARM)) begin
            fired_d[i] = 1'b1;
         end else if (bus.clr[i]) begin
            fired_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      alarm_vec = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         alarm_vec[i] = (state_q[i] == S_ALARM);
      end
   end

   // Scan downward so the lowest alarming index is the last one written.
   always_comb begin
      alarm_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (alarm_vec[i]) begin
            alarm_idx = ID_W'(i);
         end
      end
   end

   assign bus.talarm_ch = alarm_vec;
   assign bus.talarm    = |alarm_vec;
   assign bus.alarm_id  = alarm_idx;
   assign bus.fired     = fired_q;
endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;
   localparam int CH  = 4;
   localparam int DLY = 5;
   localparam int ALM = 2;

   logic clk_sys = 1'b0;
   logic rst     = 1'b1;

   always #5 clk_sys = ~clk_sys;

   alarm_bank_if #(.CHANNELS(CH)) bus_a ();
   alarm_bank_if #(.CHANNELS(1))  bus_b ();

   alarm_bank #(.CHANNELS(CH), .ALARM_DLY_TICKS(DLY), .ALARM_TICKS(ALM)) dut_a (
      .clk_sys (clk_sys),
      .rst     (rst),
      .bus     (bus_a.slave)
   );

   alarm_bank #(.CHANNELS(1), .ALARM_DLY_TICKS(0), .ALARM_TICKS(0)) dut_b (
      .clk_sys (clk_sys),
      .rst     (rst),
      .bus     (bus_b.slave)
   );

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each channel tracks only how many edges have passed
   // since its engagement started. The alarm window is an age range.
   bit            busy [CH];
   int            age  [CH];
   bit            enter;
   logic [CH-1:0] m_fired = '0;
   logic [CH-1:0] exp_ch;
   logic [1:0]    exp_id;

   initial begin
      for (int i = 0; i < CH; i++) begin
         busy[i] = 1'b0;
         age[i]  = 0;
      end
   end

   always @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            busy[i] = 1'b0;
            age[i]  = 0;
         end
         m_fired = '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            enter = 1'b0;
            if (!busy[i]) begin
               if (bus_a.engage[i]) begin
                  busy[i] = 1'b1;
                  age[i]  = 0;
               end
            end else if (age[i] <= DLY) begin
               if (!bus_a.engage[i]) begin
                  busy[i] = 1'b0;
               end else begin
                  age[i] = age[i] + 1;
                  enter  = (age[i] == DLY + 1);
               end
            end else if (age[i] <= DLY + ALM + 1) begin
               age[i] = age[i] + 1;
            end else if (!bus_a.engage[i]) begin
               busy[i] = 1'b0;
            end
            if (enter) m_fired[i] = 1'b1;
            else if (bus_a.clr[i]) m_fired[i] = 1'b0;
         end
      end
   end

   always @(negedge clk_sys) begin
      if (cmp_en) begin
         for (int i = 0; i < CH; i++) begin
            exp_ch[i] = busy[i] && (age[i] >= DLY + 1) && (age[i] <= DLY + ALM + 1);
         end
         exp_id = '0;
         for (int i = CH - 1; i >= 0; i--) begin
            if (exp_ch[i]) exp_id = 2'(i);
         end
         check("cmp_talarm_ch", 32'(bus_a.talarm_ch), 32'(exp_ch));
         check("cmp_talarm",    32'(bus_a.talarm),    32'(|exp_ch));
         check("cmp_alarm_id",  32'(bus_a.alarm_id),  32'(exp_id));
         check("cmp_fired",     32'(bus_a.fired),     32'(m_fired));
      end
   end

   // One clock edge; inputs may be changed right after returning.
   task automatic step();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic idle_steps(input int n);
      bus_a.engage = '0;
      bus_a.clr    = '0;
      repeat (n) step();
   endtask

   initial begin
      bus_a.engage = '0;
      bus_a.clr    = '0;
      bus_b.engage = '0;
      bus_b.clr    = '0;
      #1;
      check("rst_talarm_a",   32'(bus_a.talarm),    32'd0);
      check("rst_talarm_ch",  32'(bus_a.talarm_ch), 32'd0);
      check("rst_alarm_id",   32'(bus_a.alarm_id),  32'd0);
      check("rst_fired_a",    32'(bus_a.fired),     32'd0);
      check("rst_talarm_b",   32'(bus_b.talarm),    32'd0);
      repeat (2) @(posedge clk_sys);
      #2 rst = 1'b0;
      cmp_en = 1'b1;

      // Held engage on channel 0: alarm after edges 6..8, then none.
      bus_a.engage = 4'b0001;
      for (int k = 0; k <= 12; k++) begin
         step();
         check("held_talarm", 32'(bus_a.talarm), 32'((k >= 6) && (k <= 8)));
         if (k == 6) begin
            check("held_ch", 32'(bus_a.talarm_ch), 32'h1);
            check("held_id", 32'(bus_a.alarm_id),  32'h0);
         end
      end
      check("held_fired", 32'(bus_a.fired), 32'h1);
      bus_a.engage = 4'b0000;
      step();
      bus_a.engage = 4'b0001;
      for (int k = 0; k <= 7; k++) begin
         step();
         check("reengage_talarm", 32'(bus_a.talarm), 32'(k >= 6));
      end
      bus_a.clr = 4'hF;
      idle_steps(0);
      bus_a.clr = 4'hF;
      step();
      idle_steps(4);
      check("clr_fired", 32'(bus_a.fired), 32'h0);

      // Short engagement on channel 1 never alarms; re-engage restarts delay.
      bus_a.engage = 4'b0010;
      repeat (4) step();
      bus_a.engage = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         step();
         check("short_talarm", 32'(bus_a.talarm), 32'h0);
      end
      check("short_fired", 32'(bus_a.fired), 32'h0);
      bus_a.engage = 4'b0010;
      for (int k = 0; k <= 6; k++) begin
         step();
         check("restart_talarm", 32'(bus_a.talarm), 32'(k == 6));
      end
      idle_steps(4);

      // Simultaneous alarms on channels 1 and 3; channel 1 drops mid-alarm.
      bus_a.engage = 4'b1010;
      for (int k = 0; k <= 6; k++) step();
      check("dual_ch", 32'(bus_a.talarm_ch), 32'hA);
      check("dual_id", 32'(bus_a.alarm_id),  32'h1);
      bus_a.engage = 4'b1000;
      step();
      check("dual_k7", 32'(bus_a.talarm_ch), 32'hA);
      step();
      check("dual_k8", 32'(bus_a.talarm_ch), 32'hA);
      step();
      check("dual_k9", 32'(bus_a.talarm_ch), 32'h0);
      idle_steps(3);

      // Clear coinciding with alarm entry loses; a later clear wins.
      bus_a.clr    = 4'hF;
      step();
      bus_a.clr    = 4'h0;
      bus_a.engage = 4'b0001;
      for (int k = 0; k <= 5; k++) step();
      bus_a.clr = 4'b0001;
      step();
      check("clr_set_wins", 32'(bus_a.fired[0]), 32'h1);
      step();
      check("clr_later", 32'(bus_a.fired[0]), 32'h0);
      idle_steps(4);

      // Async reset between edges: ch0 alarming, ch2 in wait with count 3.
      bus_a.engage = 4'b0001;
      repeat (4) step();
      bus_a.engage = 4'b0101;
      repeat (3) step();
      check("pre_rst_talarm", 32'(bus_a.talarm), 32'h1);
      check("pre_rst_fired",  32'(bus_a.fired),  32'h1);
      #1 rst = 1'b1;
      #1;
      check("async_talarm", 32'(bus_a.talarm),    32'h0);
      check("async_ch",     32'(bus_a.talarm_ch), 32'h0);
      check("async_id",     32'(bus_a.alarm_id),  32'h0);
      check("async_fired",  32'(bus_a.fired),     32'h0);
      #2 rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         check("post_rst_ch", 32'(bus_a.talarm_ch), (k == 7) ? 32'h5 : 32'h0);
      end
      idle_steps(5);

      // Zero-delay, zero-length, single-channel instance.
      bus_b.engage = 1'b1;
      step();
      check("b_edge0", 32'(bus_b.talarm), 32'h0);
      step();
      check("b_edge1",   32'(bus_b.talarm),   32'h1);
      check("b_id",      32'(bus_b.alarm_id), 32'h0);
      check("b_fired",   32'(bus_b.fired),    32'h1);
      step();
      check("b_edge2", 32'(bus_b.talarm), 32'h0);
      step();
      check("b_hold", 32'(bus_b.talarm), 32'h0);
      bus_b.engage = 1'b0;
      step();
      bus_b.engage = 1'b1;
      step();
      step();
      check("b_again", 32'(bus_b.talarm), 32'h1);
      bus_b.engage = 1'b0;

      // Random traffic, checked every cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 9) == 0) bus_a.engage[i] = ~bus_a.engage[i];
            bus_a.clr[i] = ($urandom_range(0, 11) == 0);
         end
         step();
         if ($urandom_range(0, 399) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
      idle_steps(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
